// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmit sequencer: serialises a 48-bit command frame (start, tx, index, arg,
// CRC7, end) one bit per bit strobe, then holds the line released for GAP_BITS strobes.
module sd_cmd_tx #(
  parameter int unsigned GAP_BITS = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_bit_strobe,
  input  logic        i_abort,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [5:0]  i_cmd_index,
  input  logic [31:0] i_cmd_arg,
  output logic        o_sd_cmd,
  output logic        o_sd_cmd_oe,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned GapW = $clog2(GAP_BITS + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StData, StCrc, StEnd, StGap} state_e;

  state_e          state_q, state_d;
  logic [39:0]     shreg_q, shreg_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [6:0]      crc_q, crc_d;
  logic [6:0]      crc_bits_q, crc_bits_d;
  logic            cmd_q, cmd_d;
  logic            oe_q, oe_d;
  logic            done_q, done_d;
  logic            crc_reset, crc_shift, crc_in;

  // CRC7 engine, polynomial x^7 + x^3 + 1, fed MSB first.
  always_comb begin
    crc_d = crc_q;
    if (crc_reset) begin
      crc_d = '0;
    end else if (crc_shift) begin
      crc_d = {crc_q[5:0], 1'b0} ^ ({7{crc_q[6] ^ crc_in}} & 7'h09);
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    crc_bits_d = crc_bits_q;
    cmd_d      = cmd_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    crc_reset  = 1'b0;
    crc_shift  = 1'b0;
    crc_in     = shreg_q[39];

    if (state_q != StIdle && i_abort) begin
      state_d = StIdle;
      cmd_d   = 1'b1;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_cmd_valid) begin
            shreg_d   = {2'b01, i_cmd_index, i_cmd_arg};
            crc_reset = 1'b1;
            cnt_d     = '0;
            gap_d     = '0;
            state_d   = StLoad;
          end
        end
        // LOAD's first strobe is simply DATA bit 47.
        StLoad, StData: begin
          if (i_bit_strobe) begin
            cmd_d     = shreg_q[39];
            oe_d      = 1'b1;
            crc_shift = 1'b1;
            shreg_d   = {shreg_q[38:0], 1'b0};
            cnt_d     = cnt_q + 6'd1;
            state_d   = StData;
            if (cnt_q == 6'd39) begin
              cnt_d   = '0;
              state_d = StCrc;
            end
          end
        end
        StCrc: begin
          if (i_bit_strobe) begin
            oe_d  = 1'b1;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd0) begin
              cmd_d      = crc_q[6];
              crc_bits_d = {crc_q[5:0], 1'b0};
            end else begin
              cmd_d      = crc_bits_q[6];
              crc_bits_d = {crc_bits_q[5:0], 1'b0};
            end
            if (cnt_q == 6'd6) begin
              cnt_d   = '0;
              state_d = StEnd;
            end
          end
        end
        StEnd: begin
          if (i_bit_strobe) begin
            cmd_d   = 1'b1;
            oe_d    = 1'b1;
            gap_d   = '0;
            state_d = StGap;
          end
        end
        StGap: begin
          if (i_bit_strobe) begin
            cmd_d = 1'b1;
            oe_d  = 1'b0;
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapLast) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      crc_q      <= '0;
      crc_bits_q <= '0;
      cmd_q      <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      crc_q      <= crc_d;
      crc_bits_q <= crc_bits_d;
      cmd_q      <= cmd_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
    end
  end

  assign o_cmd_ready = (state_q == StIdle);
  assign o_busy      = (state_q != StIdle);
  assign o_sd_cmd    = cmd_q;
  assign o_sd_cmd_oe = oe_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: strobe-indexed frame model checked every cycle, plus literal frame values.
module tb_sd_cmd_tx;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_bit_strobe = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [5:0]  i_cmd_index = '0;
  logic [31:0] i_cmd_arg = '0;
  logic        o_cmd_ready, o_sd_cmd, o_sd_cmd_oe, o_busy, o_done;

  int nchk = 0;
  int nerr = 0;
  int done_cnt = 0;
  int exp_done = 0;

  sd_cmd_tx #(.GAP_BITS(GAP)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_bit_strobe (i_bit_strobe),
    .i_abort      (i_abort),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_index  (i_cmd_index),
    .i_cmd_arg    (i_cmd_arg),
    .o_sd_cmd     (o_sd_cmd),
    .o_sd_cmd_oe  (o_sd_cmd_oe),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC7 as the remainder of polynomial long division of the 40 header bits times x^7.
  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    logic [46:0] r;
    h = {2'b01, idx, arg};
    r = {h, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
    end
    return {h, r[6:0], 1'b1};
  endfunction

  // Model: k = strobes since accept; strobe k drives frame bit 48-k, done on strobe 48+GAP.
  logic        m_active, m_cmd, m_oe, m_done;
  int          m_k;
  logic [47:0] m_frame;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_cmd    <= 1'b1;
      m_oe     <= 1'b0;
      m_done   <= 1'b0;
      m_frame  <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (i_cmd_valid) begin
          m_frame  <= frame_of(i_cmd_index, i_cmd_arg);
          m_active <= 1'b1;
          m_k      <= 0;
        end
      end else if (i_abort) begin
        m_active <= 1'b0;
        m_cmd    <= 1'b1;
        m_oe     <= 1'b0;
      end else if (i_bit_strobe) begin
        m_k <= m_k + 1;
        if (m_k + 1 <= 48) begin
          m_oe  <= 1'b1;
          m_cmd <= m_frame[47-m_k];
        end else begin
          m_oe  <= 1'b0;
          m_cmd <= 1'b1;
        end
        if (m_k + 1 == 48 + GAP) begin
          m_done   <= 1'b1;
          m_active <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmd", o_sd_cmd, m_cmd);
    chk("oe", o_sd_cmd_oe, m_oe);
    chk("done", o_done, m_done);
    chk("busy", o_busy, m_active);
    chk("ready", o_cmd_ready, !m_active);
    if (o_done) done_cnt++;
  end

  // Capture every bit driven on a strobe while the line is enabled.
  logic stb_q = 1'b0;
  logic bits[$];
  always @(posedge clk) stb_q <= i_bit_strobe;
  always @(negedge clk) if (stb_q && o_sd_cmd_oe) bits.push_back(o_sd_cmd);

  task automatic check_frame(input string name, input logic [47:0] exp);
    logic [47:0] got;
    @(negedge clk);
    #1;
    if (bits.size() < 48) begin
      chk({name, "_len"}, 64'(bits.size()), 64'd48);
      bits.delete();
    end else begin
      for (int i = 47; i >= 0; i--) got[i] = bits.pop_front();
      chk(name, got, exp);
    end
  endtask

  task automatic do_strobe(input int gap);
    i_bit_strobe = 1'b1;
    @(negedge clk);
    i_bit_strobe = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input bit slow,
                      input bit stb_acc, input bit abt_acc);
    i_cmd_index  = idx;
    i_cmd_arg    = arg;
    i_cmd_valid  = 1'b1;
    i_bit_strobe = stb_acc;
    i_abort      = abt_acc;
    @(negedge clk);
    i_cmd_valid  = 1'b0;
    i_bit_strobe = 1'b0;
    i_abort      = 1'b0;
    i_cmd_index  = 6'($urandom);
    i_cmd_arg    = $urandom;
    if (slow) repeat (3) @(negedge clk);
    for (int k = 0; k < 48 + GAP; k++) do_strobe(slow ? int'($urandom_range(8, 1)) : 0);
    repeat (2) @(negedge clk);
    exp_done++;
    chk("done_count", 64'(done_cnt), 64'(exp_done));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_cmd", o_sd_cmd, 1'b1);
    chk("rst_oe", o_sd_cmd_oe, 1'b0);
    chk("rst_ready", o_cmd_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(6'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_frame("cmd0_fast", 48'h40_00_00_00_00_95);
    send(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b0);
    check_frame("cmd8", 48'h48_00_00_01_AA_87);
    send(6'd17, 32'h0, 1'b0, 1'b0, 1'b0);
    check_frame("cmd17", 48'h51_00_00_00_00_55);
    send(6'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_frame("cmd0_slow", 48'h40_00_00_00_00_95);

    // valid held through a transfer while index/arg change to the next command
    i_cmd_index  = 6'd8;
    i_cmd_arg    = 32'h1AA;
    i_cmd_valid  = 1'b1;
    i_bit_strobe = 1'b1;
    @(negedge clk);
    i_cmd_index = 6'd17;
    i_cmd_arg   = 32'h0;
    n = 0;
    while (!o_done && n < 200) begin @(negedge clk); n++; end
    chk("hold_first_done_seen", 64'(n < 200), 64'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    n = 0;
    while (!o_done && n < 200) begin @(negedge clk); n++; end
    chk("hold_second_done_seen", 64'(n < 200), 64'd1);
    i_bit_strobe = 1'b0;
    repeat (2) @(negedge clk);
    exp_done += 2;
    chk("hold_done_count", 64'(done_cnt), 64'(exp_done));
    check_frame("hold_first", 48'h48_00_00_01_AA_87);
    check_frame("hold_second", 48'h51_00_00_00_00_55);

    // abort coincident with strobe 20
    i_cmd_index = 6'd0;
    i_cmd_arg   = 32'h0;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 19; k++) do_strobe(0);
    i_abort      = 1'b1;
    i_bit_strobe = 1'b1;
    @(negedge clk);
    i_abort      = 1'b0;
    i_bit_strobe = 1'b0;
    chk("abort_oe", o_sd_cmd_oe, 1'b0);
    chk("abort_ready", o_cmd_ready, 1'b1);
    bits.delete();
    for (int k = 0; k < 3; k++) do_strobe(1);
    chk("abort_no_done", 64'(done_cnt), 64'(exp_done));
    send(6'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_frame("cmd0_after_abort", 48'h40_00_00_00_00_95);

    // asynchronous reset mid-DATA, off a clock edge
    i_cmd_index = 6'd17;
    i_cmd_arg   = 32'hDEAD_BEEF;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) do_strobe(0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cmd", o_sd_cmd, 1'b1);
    chk("arst_oe", o_sd_cmd_oe, 1'b0);
    chk("arst_ready", o_cmd_ready, 1'b1);
    chk("arst_busy", o_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bits.delete();
    @(negedge clk);
    send(6'd8, 32'h1AA, 1'b0, 1'b0, 1'b0);
    check_frame("cmd8_after_reset", 48'h48_00_00_01_AA_87);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
